// File: rtl/pipe_register_if.sv
// pipe_register_if: valid/ready handshake bundle for pipe_register
interface pipe_register_if #(parameter int DATA_WIDTH = 8, parameter int DEPTH = 3);
  localparam int CW = $clog2(DEPTH + 1);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CW-1:0]         count;
  modport master (output flush, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, count);
  modport slave  (input flush, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, count);
endinterface

// File: rtl/pipe_register.sv
// pipe_register: DEPTH-stage elastic valid/ready pipeline with flush and registered occupancy count
module pipe_register #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3
) (
  input logic             clk,
  input logic             rst_,
  pipe_register_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0]      r_v;
  logic [DATA_WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]         r_count;
  logic [DEPTH:0]        w_free;
  logic [DEPTH-1:0]      w_off;
  logic [DATA_WIDTH-1:0] w_src [DEPTH];
  logic [DEPTH-1:0]      w_load;
  logic [DEPTH-1:0]      w_v_nxt;
  logic [CW-1:0]         w_cnt;
  // a stage is free if empty or its occupant can move on this cycle
  always_comb begin
    w_free[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) w_free[i] = !r_v[i] || w_free[i+1];
    w_off[0] = bus.in_valid;
    w_src[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_off[i] = r_v[i-1];
      w_src[i] = r_d[i-1];
    end
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_load[i]  = !bus.flush && w_free[i] && w_off[i];
      w_v_nxt[i] = !bus.flush && (w_load[i] || (r_v[i] && !w_free[i]));
      w_cnt      = w_cnt + CW'(w_v_nxt[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_v     <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else begin
      r_v     <= w_v_nxt;
      r_count <= w_cnt;
      for (int i = 0; i < DEPTH; i++) if (w_load[i]) r_d[i] <= w_src[i];
    end
  end
  assign bus.in_ready  = w_free[0] && !bus.flush;
  assign bus.out_valid = r_v[DEPTH-1];
  assign bus.out_data  = r_d[DEPTH-1];
  assign bus.count     = r_count;
endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register: directed stimulus with an expected-beat queue checked by an independent output monitor
module tb_pipe_register;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] exp_q [$];
  pipe_register_if #(.DATA_WIDTH(8), .DEPTH(3)) bus ();
  pipe_register #(.DATA_WIDTH(8), .DEPTH(3)) dut (.clk(clk), .rst_(rst_), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // output monitor: every delivered beat must match the oldest expected beat
  initial forever begin
    @(negedge clk);
    if (rst_ && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL out_beat: got %0h expected no beat", bus.out_data);
      end else chk("out_beat", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end
  end
  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_count", 32'(bus.count), 0);
    step();
    rst_ = 1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    // streaming latency
    bus.out_ready = 1;
    exp_q.push_back(8'hAA); exp_q.push_back(8'h55); exp_q.push_back(8'h0F);
    bus.in_valid = 1; bus.in_data = 8'hAA;
    step();
    bus.in_data = 8'h55;
    step();
    chk("lat_not_yet", 32'(bus.out_valid), 0);
    bus.in_data = 8'h0F;
    step();
    chk("lat_valid", 32'(bus.out_valid), 1);
    chk("lat_data", 32'(bus.out_data), 32'hAA);
    bus.in_valid = 0;
    repeat (4) step();
    // backpressure
    bus.out_ready = 0;
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    bus.in_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      bus.in_data = 8'(k);
      step();
    end
    bus.in_data = 8'h04;
    #1;
    chk("bp_count", 32'(bus.count), 3);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_head", 32'(bus.out_data), 32'h01);
    step();
    chk("bp_hold_count", 32'(bus.count), 3);
    bus.out_ready = 1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0;
    repeat (4) step();
    chk("bp_drained", 32'(bus.count), 0);
    // full pass-through
    bus.out_ready = 0;
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h20 + 8'(k));
    bus.in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = 8'h20 + 8'(k);
      step();
    end
    chk("pt_full", 32'(bus.count), 3);
    bus.out_ready = 1;
    for (int k = 3; k < 8; k++) begin
      bus.in_data = 8'h20 + 8'(k);
      #1;
      chk("pt_in_ready", 32'(bus.in_ready), 1);
      step();
      chk("pt_count", 32'(bus.count), 3);
    end
    bus.in_valid = 0;
    repeat (4) step();
    // flush
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 8'h11;
    step();
    bus.in_valid = 0;
    repeat (2) step();
    bus.in_valid = 1; bus.in_data = 8'h12;
    step();
    bus.in_valid = 0;
    chk("fl_count", 32'(bus.count), 2);
    chk("fl_head", 32'(bus.out_data), 32'h11);
    exp_q.push_back(8'h11);
    bus.flush = 1; bus.out_ready = 1; bus.in_valid = 1; bus.in_data = 8'h99;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready), 0);
    step();
    bus.flush = 0; bus.in_valid = 0;
    chk("fl_count_after", 32'(bus.count), 0);
    chk("fl_valid_after", 32'(bus.out_valid), 0);
    chk("fl_data_after", 32'(bus.out_data), 32'h11);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_data", 32'(bus.out_data), 32'h11);
      chk("hold_valid", 32'(bus.out_valid), 0);
      chk("hold_count", 32'(bus.count), 0);
    end
    // asynchronous reset mid-stream
    bus.out_ready = 0;
    bus.in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = 8'h30 + 8'(k);
      step();
    end
    bus.in_valid = 0;
    chk("ar_full", 32'(bus.count), 3);
    rst_ = 0;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 0);
    chk("ar_out_data", 32'(bus.out_data), 0);
    chk("ar_count", 32'(bus.count), 0);
    step();
    rst_ = 1;
    #1;
    chk("ar_in_ready", 32'(bus.in_ready), 1);
    step();
    chk("ar_stays_empty", 32'(bus.count), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_register.md
PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, payload width in bits (1..64).
REQ-002 Parameter: DEPTH, default 3, number of register stages (1..8).
REQ-003 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port: rst_  input  1  asynchronous, active-low reset.
REQ-005 Port: flush  input  1  synchronous clear of all stage valid bits.
REQ-006 Port: in_valid  input  1  upstream has a beat on in_data.
REQ-007 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-008 Port: in_data  input  DATA_WIDTH  upstream payload.
REQ-009 Port: out_valid  output  1  last stage holds a valid beat.
REQ-010 Port: out_ready  input  1  downstream accepts a beat this cycle.
REQ-011 Port: out_data  output  DATA_WIDTH  last-stage payload register.
REQ-012 Port: count  output  $clog2(DEPTH+1)  number of stages holding valid beats.

Function
REQ-013 Each stage i (0..DEPTH-1) SHALL hold one valid bit v[i] and one DATA_WIDTH data register d[i]; stage 0 is nearest the input.
REQ-014 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-015 out_valid SHALL equal v[DEPTH-1]; out_data SHALL equal d[DEPTH-1]; both are registered, with no combinational path from in_data.
REQ-016 Stage i SHALL be "free" when !v[i], or when it is the last stage and out_ready=1, or when stage i+1 is free (ready chain, combinational from out_ready).
REQ-017 in_ready SHALL equal (stage 0 free) && !flush.
REQ-018 When stage i is free and stage i-1 (or the input, for i=0) offers a valid beat, d[i] SHALL load that beat and v[i] SHALL set at the clock edge.
REQ-019 d[i] SHALL hold its value in every cycle it does not load; a stage whose valid bit clears keeps its stale data.
REQ-020 Latency: with out_ready held 1, a beat accepted at edge N SHALL appear on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles after the input handshake cycle.
REQ-021 Throughput: with in_valid=1 and out_ready=1 continuously, one beat per cycle SHALL be accepted and delivered, with no bubbles.
REQ-022 Beats SHALL exit in acceptance order; none duplicated, none dropped, absent flush or reset.
REQ-023 Backpressure: with out_ready=0, beats SHALL compress into empty stages; once all DEPTH stages are valid, in_ready SHALL be 0.
REQ-024 Simultaneous accept and deliver with all stages full SHALL be legal: all beats shift by one stage, count unchanged.
REQ-025 flush=1 SHALL clear every v[i] at the next edge and leave d[i] unchanged.
REQ-026 An output handshake in a flush cycle SHALL complete (the beat counts as delivered); no input SHALL be accepted in that cycle.
REQ-027 count SHALL be registered and equal the number of set v[i] bits; it is 0 after a flush edge.
REQ-028 DEPTH=1 SHALL degenerate to a single valid/ready register that can accept and deliver in the same cycle when full.

Reset
REQ-029 While rst_=0, all v[i] SHALL be 0, all d[i] SHALL be 0, out_valid=0, out_data=0, and count=0, immediately and independent of clk.
REQ-030 An in-flight beat at reset assertion SHALL be discarded; in_ready SHALL be 1 on the first cycle after rst_ deasserts, if flush=0.

Verification (DATA_WIDTH=8, DEPTH=3)
REQ-031 Reset: drive rst_=0 mid-stream with 3 beats in flight -> out_valid=0, out_data=8'h00, count=0 without a clock edge.
REQ-032 Latency/streaming: hold out_ready=1 and feed 8'hAA, 8'h55, 8'h0F on consecutive cycles -> out_data shows AA, 55, 0F on three consecutive cycles, the first 3 cycles after the AA handshake.
REQ-033 Backpressure: hold out_ready=0 and offer 4 beats 8'h01..8'h04 -> 01..03 accepted, count=3, in_ready=0, 04 held upstream; then set out_ready=1 -> 01, 02, 03, 04 delivered in order.
REQ-034 Full pass-through: with count=3, in_valid=1 and out_ready=1 for 5 cycles -> 5 beats accepted and 5 delivered, count stays 3, in_ready stays 1.
REQ-035 Flush: with count=2 and out_data=8'h11, assert flush with out_ready=1 and in_valid=1 -> 8'h11 counted as delivered, input not accepted, next cycle count=0, out_valid=0, out_data still 8'h11.
REQ-036 Hold: after the flush, with in_valid=0 for 4 cycles -> out_data remains 8'h11, out_valid=0, count=0.
